// File: rtl/lf_gear_ctrl.sv
// Gain-schedule controller for the bang-bang CDR loop filter: re-init pulse,
// stepped acquisition gears, tracking gear with window-based lock detection.
module lf_gear_ctrl #(
    parameter int unsigned N_GEARS   = 4,
    parameter int unsigned DWELL     = 1024,
    parameter int unsigned KP_SH0    = 0,
    parameter int unsigned KI_SH0    = 0,
    parameter int unsigned LOCK_WIN  = 256,
    parameter int unsigned LOCK_THR  = 16,
    parameter int unsigned LOCK_GOOD = 4,
    parameter int unsigned LOCK_BAD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    output logic       lf_load,
    output logic       lf_hold,
    output logic [3:0] kp_shift,
    output logic [3:0] ki_shift,
    output logic [2:0] gear,
    output logic       locked
);

    localparam int unsigned DW_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned WIN_W  = $clog2(LOCK_WIN);
    localparam int unsigned ACC_W  = WIN_W + 2;
    localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int unsigned BAD_W  = $clog2(LOCK_BAD + 1);
    localparam logic [2:0]  TRACK_GEAR = 3'(N_GEARS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACQ   = 2'd2,
        TRACK = 2'd3
    } state_t;

    state_t                    state, state_d;
    logic [2:0]                gear_d;
    logic [3:0]                kp_d, ki_d;
    logic                      lf_load_d, lf_hold_d, locked_d;
    logic [DW_W-1:0]           dwell_cnt, dwell_d;
    logic [WIN_W-1:0]          win_cnt, win_d;
    logic signed [ACC_W-1:0]   acc, acc_d;
    logic signed [ACC_W-1:0]   step, acc_sum;
    logic [ACC_W-1:0]          acc_abs;
    logic                      win_good;
    logic [GOOD_W-1:0]         good_cnt, good_d;
    logic [BAD_W-1:0]          bad_cnt, bad_d;

    // Shift amounts are formed in 5 bits and clamped to the 4-bit output range.
    function automatic logic [3:0] shift_sat(input logic [4:0] v);
        return (v > 5'd15) ? 4'd15 : v[3:0];
    endfunction

    function automatic logic [3:0] kp_of(input logic [2:0] g);
        return shift_sat(5'(KP_SH0) + {2'b00, g});
    endfunction

    function automatic logic [3:0] ki_of(input logic [2:0] g);
        return shift_sat(5'(KI_SH0) + {1'b0, g, 1'b0});
    endfunction

    // Phase-error sample for this cycle and the window sum including it.
    assign step     = (up && !dn) ? ACC_W'(1) : ((dn && !up) ? '1 : '0);
    assign acc_sum  = acc + step;
    assign acc_abs  = acc_sum[ACC_W-1] ? (~acc_sum + ACC_W'(1)) : acc_sum;
    assign win_good = (32'(acc_abs) <= LOCK_THR);

    // State and all registered outputs/counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gear      <= 3'd0;
            kp_shift  <= kp_of(3'd0);
            ki_shift  <= ki_of(3'd0);
            lf_load   <= 1'b0;
            lf_hold   <= 1'b1;
            locked    <= 1'b0;
            dwell_cnt <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            state     <= state_d;
            gear      <= gear_d;
            kp_shift  <= kp_d;
            ki_shift  <= ki_d;
            lf_load   <= lf_load_d;
            lf_hold   <= lf_hold_d;
            locked    <= locked_d;
            dwell_cnt <= dwell_d;
            win_cnt   <= win_d;
            acc       <= acc_d;
            good_cnt  <= good_d;
            bad_cnt   <= bad_d;
        end
    end

    // Next-state, gear sequencing and lock detection.
    always_comb begin
        state_d   = state;
        gear_d    = gear;
        lf_load_d = 1'b0;
        lf_hold_d = 1'b0;
        locked_d  = locked;
        dwell_d   = dwell_cnt;
        win_d     = win_cnt;
        acc_d     = acc;
        good_d    = good_cnt;
        bad_d     = bad_cnt;

        if (!en) begin
            state_d   = IDLE;
            gear_d    = 3'd0;
            lf_hold_d = 1'b1;
            locked_d  = 1'b0;
            dwell_d   = '0;
            win_d     = '0;
            acc_d     = '0;
            good_d    = '0;
            bad_d     = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d   = LOAD;
                    gear_d    = 3'd0;
                    lf_load_d = 1'b1;
                    lf_hold_d = 1'b1;
                end
                LOAD: begin
                    state_d = ACQ;
                    gear_d  = 3'd0;
                    dwell_d = '0;
                end
                ACQ: begin
                    if (dwell_cnt == DW_W'(DWELL - 1)) begin
                        dwell_d = '0;
                        gear_d  = gear + 3'd1;
                        if (gear_d == TRACK_GEAR) begin
                            // Detector starts clean on every TRACK entry.
                            state_d = TRACK;
                            win_d   = '0;
                            acc_d   = '0;
                            good_d  = '0;
                            bad_d   = '0;
                        end
                    end else begin
                        dwell_d = dwell_cnt + DW_W'(1);
                    end
                end
                TRACK: begin
                    win_d = win_cnt + WIN_W'(1);
                    if (win_cnt == WIN_W'(LOCK_WIN - 1)) begin
                        acc_d = '0;
                        if (!locked) begin
                            if (!win_good) begin
                                good_d = '0;
                            end else if (good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
                                good_d   = '0;
                                locked_d = 1'b1;
                            end else begin
                                good_d = good_cnt + GOOD_W'(1);
                            end
                        end else begin
                            if (win_good) begin
                                bad_d = '0;
                            end else if (bad_cnt == BAD_W'(LOCK_BAD - 1)) begin
                                // Lock loss: restart acquisition, filter state kept.
                                state_d  = ACQ;
                                gear_d   = 3'd0;
                                locked_d = 1'b0;
                                dwell_d  = '0;
                                win_d    = '0;
                                good_d   = '0;
                                bad_d    = '0;
                            end else begin
                                bad_d = bad_cnt + BAD_W'(1);
                            end
                        end
                    end else begin
                        acc_d = acc_sum;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    gear_d    = 3'd0;
                    lf_hold_d = 1'b1;
                end
            endcase
        end

        kp_d = kp_of(gear_d);
        ki_d = ki_of(gear_d);
    end

endmodule

// File: tb/tb_lf_gear_ctrl.sv
// Directed bench for lf_gear_ctrl with default parameters.
module tb_lf_gear_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       dn;
    logic       lf_load;
    logic       lf_hold;
    logic [3:0] kp_shift;
    logic [3:0] ki_shift;
    logic [2:0] gear;
    logic       locked;

    int checks   = 0;
    int failures = 0;
    int load_cnt = 0;
    int l0;

    lf_gear_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .dn       (dn),
        .lf_load  (lf_load),
        .lf_hold  (lf_hold),
        .kp_shift (kp_shift),
        .ki_shift (ki_shift),
        .gear     (gear),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which the filter reload pulse is high.
    always @(negedge clk) begin
        if (lf_load === 1'b1) load_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 256-cycle detector window: mode 0 = |net| pulses of up (net>0) or dn (net<0),
    // mode 1 = alternating up/dn, mode 2 = up and dn together every cycle.
    task automatic run_window(input int mode, input int net);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0: begin
                    up = (net > 0) && (i < net);
                    dn = (net < 0) && (i < -net);
                end
                1: begin
                    up = (i % 2) == 0;
                    dn = (i % 2) == 1;
                end
                default: begin
                    up = 1'b1;
                    dn = 1'b1;
                end
            endcase
            @(negedge clk);
        end
        up = 1'b0;
        dn = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic ld, input logic hd,
                              input logic [3:0] kp, input logic [3:0] ki,
                              input logic [2:0] g, input logic lk);
        check({tag, ".lf_load"},  32'(lf_load),  32'(ld));
        check({tag, ".lf_hold"},  32'(lf_hold),  32'(hd));
        check({tag, ".kp_shift"}, 32'(kp_shift), 32'(kp));
        check({tag, ".ki_shift"}, 32'(ki_shift), 32'(ki));
        check({tag, ".gear"},     32'(gear),     32'(g));
        check({tag, ".locked"},   32'(locked),   32'(lk));
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        up    = 1'b0;
        dn    = 1'b0;
        #2 rst_n = 1'b0;
        tick(2);
        check_outs("reset", 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick(2);
        check_outs("idle", 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0);

        // Full acquisition with quiet phase detector.
        l0 = load_cnt;
        en = 1'b1;
        tick(1);
        check_outs("load", 1'b1, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0);
        tick(1);
        check_outs("acq0", 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        tick(1023);
        check("acq0_end.gear", 32'(gear), 32'd0);
        tick(1);
        check_outs("acq1", 1'b0, 1'b0, 4'd1, 4'd2, 3'd1, 1'b0);
        tick(1024);
        check_outs("acq2", 1'b0, 1'b0, 4'd2, 4'd4, 3'd2, 1'b0);
        tick(1024);
        check_outs("track", 1'b0, 1'b0, 4'd3, 4'd6, 3'd3, 1'b0);
        check("load_pulse_once", 32'(load_cnt - l0), 32'd1);
        tick(1023);
        check("prelock.locked", 32'(locked), 32'd0);
        tick(1);
        check("lock.locked", 32'(locked), 32'd1);

        // Locked: single bad windows and threshold boundaries must not drop lock.
        run_window(0, 17);
        check("lk_w17.locked", 32'(locked), 32'd1);
        run_window(0, 16);
        check("lk_w16.locked", 32'(locked), 32'd1);
        run_window(0, 17);
        check("lk_w17b.locked", 32'(locked), 32'd1);
        run_window(2, 0);
        check("lk_both.locked", 32'(locked), 32'd1);
        run_window(0, 256);
        check("lk_up1.locked", 32'(locked), 32'd1);
        run_window(0, -16);
        check("lk_dn16.locked", 32'(locked), 32'd1);
        l0 = load_cnt;
        run_window(0, 256);
        check("lk_bad1.locked", 32'(locked), 32'd1);
        run_window(0, 256);
        check_outs("lossreacq", 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        check("loss_no_load", 32'(load_cnt - l0), 32'd0);

        // Re-acquisition steps through the gears again.
        tick(1023);
        check("reacq0.gear", 32'(gear), 32'd0);
        tick(1);
        check("reacq1.gear", 32'(gear), 32'd1);
        tick(2048);
        check_outs("retrack", 1'b0, 1'b0, 4'd3, 4'd6, 3'd3, 1'b0);

        // Unlocked tracking: constant up never locks; a bad window restarts the good count.
        for (int w = 0; w < 4; w++) run_window(0, 256);
        check("noisy.locked", 32'(locked), 32'd0);
        run_window(1, 0);
        run_window(1, 0);
        run_window(1, 0);
        check("alt3.locked", 32'(locked), 32'd0);
        run_window(0, 17);
        check("w17.locked", 32'(locked), 32'd0);
        run_window(0, 16);
        run_window(2, 0);
        run_window(0, -16);
        check("good3.locked", 32'(locked), 32'd0);
        run_window(1, 0);
        check("good4.locked", 32'(locked), 32'd1);
        check("good4.gear", 32'(gear), 32'd3);

        // Asynchronous reset while locked in TRACK.
        #1 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0);
        @(negedge clk);
        check_outs("rst_hold", 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0);
        rst_n = 1'b1;

        // en dropped during gear 2, then restarted.
        tick(1);
        check("reload.lf_load", 32'(lf_load), 32'd1);
        tick(1);
        tick(2048);
        tick(5);
        check("mid_acq2.gear", 32'(gear), 32'd2);
        en = 1'b0;
        tick(1);
        check_outs("en_drop", 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0);
        l0 = load_cnt;
        tick(3);
        check("idle_wait.lf_hold", 32'(lf_hold), 32'd1);
        en = 1'b1;
        tick(1);
        check_outs("fresh_load", 1'b1, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0);
        tick(1);
        check_outs("fresh_acq", 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        check("fresh_load_once", 32'(load_cnt - l0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
